// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end: reset/exception defaults,
// sequencer states and redirect-source priority ranks.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_0180;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;

  // Higher value wins when a held redirect meets a new one.
  localparam logic [1:0] PRI_NONE = 2'd0;
  localparam logic [1:0] PRI_BR   = 2'd1;
  localparam logic [1:0] PRI_JMP  = 2'd2;
  localparam logic [1:0] PRI_EXC  = 2'd3;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_incr4.sv
// Combinational PC + 4 incrementer; wraps modulo 2^32 with no carry out.
module pc_incr4 (
  input  logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + 32'd4;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner: issues one fetch per PC under req/ack, honours stalls
// and applies or holds exception/jump/branch redirects by priority.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Br_Taken,
  input  logic [31:0] Br_Target,
  input  logic        Jmp,
  input  logic [31:0] Jmp_Target,
  input  logic        Exc,
  input  logic        Fetch_Ack,
  output logic        Fetch_Req,
  output logic [31:0] Fetch_Addr,
  output logic [31:0] PC_Plus4,
  output logic        Pend
);

  pc_state_e   state_r;
  pc_state_e   state_nxt_s;
  logic [31:0] pc_r;
  logic        fetch_req_r;
  logic        pend_r;
  logic [31:0] pend_tgt_r;
  logic [1:0]  pend_pri_r;

  logic        adv_s;
  logic        redir_s;
  logic [31:0] redir_tgt_s;
  logic [1:0]  redir_pri_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] next_pc_s;

  pc_incr4 u_incr4 (
    .pc       (pc_r),
    .pc_plus4 (pc_plus4_s)
  );

  // Select the highest-priority redirect presented this cycle.
  always_comb begin
    redir_s     = 1'b0;
    redir_tgt_s = 32'h0000_0000;
    redir_pri_s = PRI_NONE;
    if (Exc) begin
      redir_s     = 1'b1;
      redir_tgt_s = align_word(EXC_VEC);
      redir_pri_s = PRI_EXC;
    end else if (Jmp) begin
      redir_s     = 1'b1;
      redir_tgt_s = align_word(Jmp_Target);
      redir_pri_s = PRI_JMP;
    end else if (Br_Taken) begin
      redir_s     = 1'b1;
      redir_tgt_s = align_word(Br_Target);
      redir_pri_s = PRI_BR;
    end else begin
      redir_s     = 1'b0;
      redir_tgt_s = 32'h0000_0000;
      redir_pri_s = PRI_NONE;
    end
  end

  // Next PC: a fresh redirect beats a held one, which beats sequential flow.
  always_comb begin
    next_pc_s = pc_plus4_s;
    if (redir_s) begin
      next_pc_s = redir_tgt_s;
    end else if (pend_r) begin
      next_pc_s = pend_tgt_r;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // Fetch FSM: an acked PC is never re-requested; HOLD waits out the stall.
  always_comb begin
    state_nxt_s = state_r;
    adv_s       = 1'b0;
    case (state_r)
      BOOT: begin
        state_nxt_s = REQ;
      end
      REQ: begin
        if (Fetch_Ack && !Stall) begin
          adv_s       = 1'b1;
          state_nxt_s = REQ;
        end else if (Fetch_Ack) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = REQ;
        end
      end
      HOLD: begin
        if (!Stall) begin
          adv_s       = 1'b1;
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = BOOT;
      end
    endcase
  end

  // State, PC and held-redirect registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r     <= BOOT;
      pc_r        <= RESET_PC;
      fetch_req_r <= 1'b0;
      pend_r      <= 1'b0;
      pend_tgt_r  <= 32'h0000_0000;
      pend_pri_r  <= PRI_NONE;
    end else begin
      state_r     <= state_nxt_s;
      fetch_req_r <= (state_nxt_s == REQ);
      if (adv_s) begin
        pc_r       <= next_pc_s;
        pend_r     <= 1'b0;
        pend_tgt_r <= 32'h0000_0000;
        pend_pri_r <= PRI_NONE;
      end else if (redir_s && (!pend_r || (redir_pri_s >= pend_pri_r))) begin
        // Equal rank overwrites so the most recent same-source redirect wins.
        pend_r     <= 1'b1;
        pend_tgt_r <= redir_tgt_s;
        pend_pri_r <= redir_pri_s;
      end else begin
        pend_r     <= pend_r;
        pend_tgt_r <= pend_tgt_r;
        pend_pri_r <= pend_pri_r;
      end
    end
  end

  assign Fetch_Req  = fetch_req_r;
  assign Fetch_Addr = pc_r;
  assign PC_Plus4   = pc_plus4_s;
  assign Pend       = pend_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: accepted fetch addresses are checked by a
// scoreboard monitor; reset, stall and pending state are checked inline.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        exc;
  logic        fetch_ack;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] pc_plus4;
  logic        pend;

  int n_vec;
  int n_miss;
  logic [31:0] exp_q[$];

  pc_sequencer dut (
    .Clk        (clk),
    .Rst_n      (rst_n),
    .Stall      (stall),
    .Br_Taken   (br_taken),
    .Br_Target  (br_target),
    .Jmp        (jmp),
    .Jmp_Target (jmp_target),
    .Exc        (exc),
    .Fetch_Ack  (fetch_ack),
    .Fetch_Req  (fetch_req),
    .Fetch_Addr (fetch_addr),
    .PC_Plus4   (pc_plus4),
    .Pend       (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted fetch must match the next expected PC.
  always @(negedge clk) begin
    if (rst_n && fetch_req && fetch_ack) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sb_unexpected: got fetch 0x%08h, required no fetch", fetch_addr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_fetch_addr", fetch_addr, e);
        chk("sb_pc_plus4", pc_plus4, e + 32'd4);
      end
    end
  end

  // Apply the currently set inputs for one edge, then clear the pulses.
  task automatic step(input logic ack, input logic stl, input logic push, input logic [31:0] exp);
    fetch_ack = ack;
    stall     = stl;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    fetch_ack = 1'b0;
    stall     = 1'b0;
    br_taken  = 1'b0;
    jmp       = 1'b0;
    exc       = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    jmp = 1'b0; jmp_target = 32'h0; exc = 1'b0; fetch_ack = 1'b0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_req", {31'd0, fetch_req}, 32'd0);
    chk("rst_pend", {31'd0, pend}, 32'd0);
    chk("rst_addr", fetch_addr, 32'h0000_0000);
    rst_n = 1'b1;
    chk("boot_req", {31'd0, fetch_req}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("first_req", {31'd0, fetch_req}, 32'd1);
    chk("first_addr", fetch_addr, 32'h0000_0000);
    chk("first_plus4", pc_plus4, 32'h0000_0004);

    // Sequential fetch, then stall with branch at PC 8
    step(1'b1, 1'b0, 1'b1, 32'h0000_0000);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0004);
    br_taken = 1'b1; br_target = 32'h0000_0100;
    step(1'b1, 1'b1, 1'b1, 32'h0000_0008);
    chk("hold_req", {31'd0, fetch_req}, 32'd0);
    chk("hold_pend", {31'd0, pend}, 32'd1);
    chk("hold_addr", fetch_addr, 32'h0000_0008);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("hold2_addr", fetch_addr, 32'h0000_0008);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("br_addr", fetch_addr, 32'h0000_0100);
    chk("br_pend", {31'd0, pend}, 32'd0);
    chk("br_req", {31'd0, fetch_req}, 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0104);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("noack_stable", fetch_addr, 32'h0000_0108);

    // Simultaneous redirects
    jmp = 1'b1; jmp_target = 32'h0000_0200; br_taken = 1'b1; br_target = 32'h0000_0300;
    step(1'b1, 1'b0, 1'b1, 32'h0000_0108);
    chk("jmp_over_br", fetch_addr, 32'h0000_0200);
    jmp = 1'b1; br_taken = 1'b1; exc = 1'b1;
    step(1'b1, 1'b0, 1'b1, 32'h0000_0200);
    chk("exc_over_all", fetch_addr, 32'h0000_0180);

    // Pending override: branch held, jump overwrites
    br_taken = 1'b1; br_target = 32'h0000_0300;
    step(1'b1, 1'b1, 1'b1, 32'h0000_0180);
    jmp = 1'b1; jmp_target = 32'h0000_0400;
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("pend_jmp_wins", fetch_addr, 32'h0000_0400);
    chk("pend_clr", {31'd0, pend}, 32'd0);
    // Reverse order: jump held, later branch must not overwrite
    jmp = 1'b1; jmp_target = 32'h0000_0400;
    step(1'b1, 1'b1, 1'b1, 32'h0000_0400);
    br_taken = 1'b1; br_target = 32'h0000_0300;
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("pend_br_loses", fetch_addr, 32'h0000_0400);

    // Alignment and wrap
    jmp = 1'b1; jmp_target = 32'h0000_0203;
    step(1'b1, 1'b0, 1'b1, 32'h0000_0400);
    chk("align", fetch_addr, 32'h0000_0200);
    jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
    step(1'b1, 1'b0, 1'b1, 32'h0000_0200);
    chk("wrap_plus4", pc_plus4, 32'h0000_0000);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_addr", fetch_addr, 32'h0000_0000);

    // Redirect during an un-acked request is held, then applied
    br_taken = 1'b1; br_target = 32'h0000_0500;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("req_pend", {31'd0, pend}, 32'd1);
    chk("req_pend_addr", fetch_addr, 32'h0000_0000);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0000);
    chk("req_pend_apply", fetch_addr, 32'h0000_0500);
    // Direct redirect at advance discards the held one
    br_taken = 1'b1; br_target = 32'h0000_0600;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    jmp = 1'b1; jmp_target = 32'h0000_0700;
    step(1'b1, 1'b0, 1'b1, 32'h0000_0500);
    chk("discard_addr", fetch_addr, 32'h0000_0700);
    chk("discard_pend", {31'd0, pend}, 32'd0);

    // Reset mid-request at PC 0x40 with a held redirect
    jmp = 1'b1; jmp_target = 32'h0000_0040;
    step(1'b1, 1'b0, 1'b1, 32'h0000_0700);
    br_taken = 1'b1; br_target = 32'h0000_0800;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("mid_pre_req", {31'd0, fetch_req}, 32'd1);
    chk("mid_pre_addr", fetch_addr, 32'h0000_0040);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("mid_req", {31'd0, fetch_req}, 32'd0);
    chk("mid_addr", fetch_addr, 32'h0000_0000);
    chk("mid_pend", {31'd0, pend}, 32'd0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("mid_boot_ack_ign", fetch_addr, 32'h0000_0000);

    // Exception during BOOT is held and applied on first advance
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    exc = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("boot_exc_pend", {31'd0, pend}, 32'd1);
    chk("boot_exc_addr", fetch_addr, 32'h0000_0000);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0000);
    chk("boot_exc_apply", fetch_addr, 32'h0000_0180);
    chk("boot_exc_clr", {31'd0, pend}, 32'd0);

    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
